// File: rtl/mem_bus_pkg.sv
// Shared types and sizing helpers for the CPU memory bus interface.
// The optional MEM_BUS_MISALIGN_CHECK_EN build rejects misaligned full-word accesses.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } bus_state_t;

  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // A disabled timeout still gets a 1-bit counter so the port widths stay legal.
  function automatic int unsigned ctr_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-state counter: flags the last allowed BUSY cycle without a response.
module bus_timeout_ctr
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = ctr_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LAST so the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/mem_bus_if.sv
// CPU-side bus interface unit: one valid/ready transaction per CPU strobe, with fault reporting.
// Optional build macro MEM_BUS_MISALIGN_CHECK_EN faults misaligned full-word accesses without a bus cycle.
module mem_bus_if
  import mem_bus_pkg::*;
#(
  parameter  int unsigned ADDR_W  = 32,
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned BE_W    = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [BE_W-1:0]   cpu_be,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  output logic              mem_we,
  output logic              mem_valid,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);

  bus_state_t state;
  logic       strobe_c;
  logic       misalign_c;
  logic       tmo_clear_c;
  logic       tmo_enable_c;
  logic       tmo_expired;

  assign strobe_c = cpu_read | cpu_write;

`ifdef MEM_BUS_MISALIGN_CHECK_EN
  localparam int unsigned AL_W = (BE_W > 1) ? $clog2(BE_W) : 1;
  assign misalign_c = (BE_W > 1) && (&cpu_be) && (cpu_addr[AL_W-1:0] != '0);
`else
  assign misalign_c = 1'b0;
`endif

  assign tmo_clear_c  = (state != BUSY);
  assign tmo_enable_c = (state == BUSY) && !mem_ready;

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear_c),
    .enable  (tmo_enable_c),
    .expired (tmo_expired)
  );

  // Stall is asserted in the strobe cycle itself so the CPU holds before the request registers.
  assign cpu_stall = ((state == IDLE) && strobe_c) || (state == BUSY) || (state == ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      bus_error <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe_c) begin
            if (misalign_c) begin
              state     <= ERROR;
              bus_error <= 1'b1;
            end else begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_be    <= cpu_be;
              mem_we    <= cpu_write;
              mem_valid <= 1'b1;
              state     <= BUSY;
            end
          end
        end
        // A response in the expiry cycle takes priority over the timeout.
        BUSY: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (mem_err) begin
              bus_error <= 1'b1;
              state     <= ERROR;
            end else begin
              if (!mem_we) begin
                cpu_rdata <= mem_rdata;
              end
              state <= DONE;
            end
          end else if (tmo_expired) begin
            mem_valid <= 1'b0;
            bus_error <= 1'b1;
            state     <= ERROR;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
